toggle_scheduler: RTL
=====================

# toggle_scheduler

Drives a single output level whose transitions are scheduled by queued delay commands. Each accepted command waits a programmed number of cycles and then toggles the output, with a one-cycle `positive_edge` or `negative_edge` strobe marking the change. It is the generator counterpart of `edge_detector`: it produces the level waveform that block consumes, and it serves as the stimulus and pattern source in component benches and timing logic.

## Interface
- `DELAY_W`, 8: width of the per-command delay field.
- `DEPTH`, 4: command FIFO depth; must be a power of 2 and at least 2.
- `INIT_LEVEL`, 1'b0: value of `out` after reset.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort; clears all pending work.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted; equals `!full && !flush`.
- `cmd_delay`  in  DELAY_W  cycles to wait before the toggle.
- `out`  out  1  generated level.
- `positive_edge`  out  1  high for exactly the first cycle in which `out` is 1 after a 0→1 toggle.
- `negative_edge`  out  1  high for exactly the first cycle in which `out` is 0 after a 1→0 toggle.
- `busy`  out  1  FSM is in WAIT.
- `pending`  out  $clog2(DEPTH+1)  number of commands queued in the FIFO; excludes the one currently in WAIT.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_delay` is captured into the FIFO. Data is not required to stay stable once accepted.
- The FSM has two states, IDLE and WAIT. All registers, including the counter (DELAY_W bits), are updated on `clk`.
- IDLE with FIFO non-empty: pop the head, load `counter <= head`, go to WAIT.
- WAIT with `counter != 0`: decrement the counter.
- WAIT with `counter == 0`:
  - toggle `out` and raise the matching strobe for the next cycle;
  - if the FIFO is non-empty, pop and reload the counter in the same edge and stay in WAIT (back-to-back, no gap);
  - otherwise go to IDLE.
- Arithmetic: the counter never wraps; it decrements only when non-zero.
- A delay of 0 toggles on the edge after the pop.
- Simultaneous push and pop in one edge is legal and leaves `pending` unchanged. A push while full cannot occur because `cmd_ready` is low.
- `flush` has priority over everything except reset:
  - FIFO emptied, FSM to IDLE, counter to 0;
  - `out` is held at its current value;
  - strobes are 0 the next cycle;
  - no command is accepted in the flush cycle.
- Reset, asserted at any time including mid-wait:
  - `out = INIT_LEVEL`, strobes 0, `busy` 0, `pending` 0, FSM IDLE, counter 0;
  - `cmd_ready` is 1 while in reset, provided `flush` is low.

## Timing
- A command accepted at edge A into an idle, empty block is popped at edge A+1. `out` toggles at edge A+1+d+1 = A+d+2, where d is `cmd_delay`.
- Back-to-back commands: successive toggles are d_next+1 cycles apart.
- Strobes are registered and go high in the same cycle `out` takes its new value; they are never both high.
- `busy` rises at the pop edge. It falls at the final toggle edge when the FIFO is empty.
- `pending` updates at the accept and pop edges.

## Structure
- Package `toggle_scheduler_pkg` holds the `state_t` enum (IDLE, WAIT) and the default parameter constants.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides push/pop, full/empty and count.
  - Read-first behaviour on a simultaneous push and pop.
  - Uses the same `clk` and the same active-low asynchronous `rst`.
- `toggle_scheduler` contains the FSM, the down-counter and the registered `out`/strobe logic.

## Test plan
- Reset release, then a single command with delay 3 accepted at edge A → `out` goes 0→1 at edge A+5, `positive_edge` is high for exactly one cycle, `busy` is high from edge A+1 to edge A+5.
- Three back-to-back commands with delays 0, 2, 1 → toggles 1, 3 and 2 cycles apart respectively; the strobes alternate positive, negative, positive; `pending` decrements with each pop.
- DEPTH+1 consecutive valid commands while one is waiting with delay 20 → `cmd_ready` drops once the FIFO holds 4; the extra command is held off, not lost; ready reasserts after the next pop.
- `flush` during WAIT with counter = 5 and 2 pending → `out` unchanged, no strobe, `pending` 0, `busy` 0; a command issued in the same cycle is not accepted.
- `rst` asserted asynchronously mid-wait with `out` = 1 → `out` is INIT_LEVEL (0) immediately and all state is cleared; after release, a delay-0 command toggles `out` to 1 two edges after accept.
- Loopback into `edge_detector` with 10 random delays in 1..128 → the detector's edge pulses match this block's strobes one-for-one, each one cycle later.

Source files
------------

// File: rtl/toggle_scheduler_pkg.sv
// Shared types and default parameter values for the toggle scheduler.
// The FSM has two states: IDLE, and WAIT while a delay counts down.
package toggle_scheduler_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int   DEF_DELAY_W    = 8;
   localparam int   DEF_DEPTH      = 4;
   localparam logic DEF_INIT_LEVEL = 1'b0;

endpackage

// File: rtl/toggle_scheduler_if.sv
// Command handshake and status bundle of the toggle scheduler.
// The master drives commands and flush; the slave is the scheduler itself.
interface toggle_scheduler_if
   import toggle_scheduler_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int DEPTH   = DEF_DEPTH
);
   logic                         flush;
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [DELAY_W-1:0]           cmd_delay;
   logic                         out;
   logic                         positive_edge;
   logic                         negative_edge;
   logic                         busy;
   logic [$clog2(DEPTH+1)-1:0]   pending;

   modport master (
      output flush, cmd_valid, cmd_delay,
      input  cmd_ready, out, positive_edge, negative_edge, busy, pending
   );

   modport slave (
      input  flush, cmd_valid, cmd_delay,
      output cmd_ready, out, positive_edge, negative_edge, busy, pending
   );
endinterface

// File: rtl/toggle_scheduler_sync_fifo.sv
// Synchronous FIFO with a show-ahead head and occupancy count.
// On a simultaneous push and pop the old head is read before the write lands.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; power-of-2 depth lets the pointers wrap naturally
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push && !i_clr) begin
         r_mem[r_wr_ptr] <= i_din;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         else           r_wr_ptr <= r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         else           r_rd_ptr <= r_rd_ptr;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/toggle_scheduler.sv
// Level generator: each queued delay command waits its count, then toggles
// the output and pulses the matching edge strobe for one cycle.
module toggle_scheduler
   import toggle_scheduler_pkg::*;
#(
   parameter int   DELAY_W    = DEF_DELAY_W,
   parameter int   DEPTH      = DEF_DEPTH,
   parameter logic INIT_LEVEL = DEF_INIT_LEVEL
) (
   input  logic              i_clk,
   input  logic              i_rst,
   toggle_scheduler_if.slave bus
);
   state_t                     r_state;
   logic [DELAY_W-1:0]         r_counter;
   logic                       r_out;
   logic                       r_pos;
   logic                       r_neg;
   logic [DELAY_W-1:0]         w_head;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_expired;
   logic [$clog2(DEPTH+1)-1:0] w_count;

   assign bus.cmd_ready     = !w_full && !bus.flush;
   assign bus.out           = r_out;
   assign bus.positive_edge = r_pos;
   assign bus.negative_edge = r_neg;
   assign bus.busy          = (r_state == WAIT);
   assign bus.pending       = w_count;

   assign w_push    = bus.cmd_valid && bus.cmd_ready;
   assign w_expired = (r_state == WAIT) && (r_counter == '0);
   assign w_pop     = !bus.flush && !w_empty && ((r_state == IDLE) || w_expired);

   sync_fifo #(
      .WIDTH (DELAY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (bus.flush),
      .i_push  (w_push),
      .i_din   (bus.cmd_delay),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // FSM, down-counter and registered level/strobes; flush keeps the level
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= IDLE;
         r_counter <= '0;
         r_out     <= INIT_LEVEL;
         r_pos     <= 1'b0;
         r_neg     <= 1'b0;
      end else if (bus.flush) begin
         r_state   <= IDLE;
         r_counter <= '0;
         r_pos     <= 1'b0;
         r_neg     <= 1'b0;
      end else begin
         r_pos <= 1'b0;
         r_neg <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_counter <= w_head;
                  r_state   <= WAIT;
               end else begin
                  r_state   <= IDLE;
               end
            end
            WAIT: begin
               if (r_counter != '0) begin
                  r_counter <= r_counter - 1'b1;
               end else begin
                  r_out <= ~r_out;
                  r_pos <= ~r_out;
                  r_neg <= r_out;
                  if (!w_empty) r_counter <= w_head;
                  else          r_state   <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_counter <= '0;
            end
         endcase
      end
   end
endmodule
